rr_regfile_arbiter: RTL
=======================

// Module: rr_regfile_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one DEPTH x DW register array
//   (the reg [7:0] mem [31:0] style store) between NREQ requesters.
//   Each access is either a single-word read or a single-word write.
//   Sits between requester logic and the array; owns the array and its only port.
//   A 3-state FSM sequences arbitration, access and read response.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   AW     5   address width; DEPTH = 2**AW words (32)
//   DW     8   data width
//   IDW    2   requester-id width, clog2(NREQ)
// PORTS
//   clk     in   1         single clock, all state on posedge
//   rst_n   in   1         reset, asynchronous, active-low
//   req     in   NREQ      per-requester access request
//   we      in   NREQ      per-requester 1=write 0=read, valid with req
//   addr    in   NREQ*AW   packed addresses, requester k at [k*AW +: AW]
//   wdata   in   NREQ*DW   packed write data, requester k at [k*DW +: DW]
//   gnt     out  NREQ      one-hot grant, high for exactly one cycle per access
//   rvalid  out  1         read data valid, one-cycle pulse
//   rdata   out  DW        read data, held until next read completes
//   rid     out  IDW       id of requester owning rdata
//   busy    out  1         1 when FSM not in IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, ptr=0, gnt=0, rvalid=0, rdata=0,
//     rid=0, busy=0, every array word cleared to 0; takes effect without a clock edge.
//   All outputs are registered; no combinational input->output path.
//   IDLE: if |req, pick winner w = first set req bit scanning ptr, ptr+1, ...
//     mod NREQ; latch sel=w, we[w], addr[w], wdata[w]; go ACCESS. Else stay.
//   ACCESS (1 cycle): gnt[sel]=1.
//     Write: mem[addr] <= wdata at the closing edge; ptr <= (sel+1) mod NREQ;
//       go IDLE.
//     Read: rdata <= mem[addr], rid <= sel; go RESP.
//   RESP (1 cycle): rvalid=1; ptr <= (sel+1) mod NREQ; go IDLE.
//   Latency: req sampled at edge 0 -> gnt high in cycle 1 -> write visible
//     from cycle 2; read rvalid in cycle 2.
//   Throughput: a write occupies 2 cycles; a read occupies 3.
//   Requester holds req until its gnt. Once latched in IDLE, an access is
//     committed: dropping req, or changing addr/wdata, afterwards has no effect.
//   A requester still asserting req after its gnt is served again at its
//     next round-robin turn; no requester is skipped twice in a row.
//   Simultaneous requests are resolved by ptr only. Requester index is
//     never used as a fixed priority.
//   Read after write to the same address returns the new data: the write
//     commits before the following IDLE cycle.
//   addr is always in range, since DEPTH = 2**AW.
//   Reset mid-operation: state aborts to IDLE.
//     Reset during ACCESS before the edge: the write is not performed.
//     Reset during RESP: rvalid falls immediately.
//     ptr returns to 0.
// TESTING
//   1 reset: hold rst_n=0 mid-run -> gnt=0, rvalid=0, rdata=0, busy=0 at once;
//     after release, read addr 3 -> rdata=8'h00, rid=0.
//   2 write/read: req0 write addr 5 = 8'hA5 -> gnt=4'b0001 in cycle 1;
//     then req0 read addr 5 -> rvalid cycle 2, rdata=8'hA5, rid=0.
//   3 fan-in: after reset, req=4'b1111, all reads -> gnt 0001,0010,0100,1000
//     at 3-cycle spacing; rid=0,1,2,3 in order.
//   4 fairness: req0 and req2 write continuously -> grants alternate
//     0,2,0,2 every 2 cycles; req1/req3 never granted.
//   5 withdrawal: req1 read pulse one cycle only -> gnt[1] still in cycle 1,
//     rvalid cycle 2 with rid=1.
//   6 abort: pull rst_n low during ACCESS of write 8'h3C to addr 7 ->
//     after release, read addr 7 returns 8'h00.

Source files
------------

// File: rtl/rr_regfile_arbiter_if.sv
// Requester-side bus of the round-robin register-file arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface rr_regfile_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 8,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               rvalid;
    logic [DW-1:0]      rdata;
    logic [IDW-1:0]     rid;
    logic               busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, rid, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, rid, busy
    );
endinterface

// File: rtl/rr_regfile_arbiter.sv
// Round-robin arbiter that owns a 2**AW x DW register array and serialises
// single-word reads and writes from NREQ requesters. All outputs are registered.
module rr_regfile_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_regfile_arbiter_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  sel_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [NREQ-1:0] gnt_q;
    logic            rvalid_q;
    logic [DW-1:0]   rdata_q;
    logic [IDW-1:0]  rid_q;
    logic            busy_q;
    logic [DW-1:0]   mem [DEPTH];

    logic [IDW-1:0]  win;
    logic [NREQ-1:0] win_onehot;
    logic            any_req;
    logic [IDW-1:0]  ptr_next;
    int unsigned     idx;

    // Winner: first asserted request scanning from ptr upward, wrapping at NREQ.
    always_comb begin
        win        = '0;
        any_req    = 1'b0;
        idx        = 0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!any_req && bus.req[idx]) begin
                win     = IDW'(idx);
                any_req = 1'b1;
            end
        end
        win_onehot[win] = 1'b1;
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        ptr_next = IDW'((32'(sel_q) + 1) % NREQ);
    end

    // Sequencer FSM, array port and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Latching here commits the access; later req/addr changes are ignored.
                    if (any_req) begin
                        sel_q   <= win;
                        we_q    <= bus.we[win];
                        addr_q  <= bus.addr[32'(win) * AW +: AW];
                        wdata_q <= bus.wdata[32'(win) * DW +: DW];
                        gnt_q   <= win_onehot;
                        busy_q  <= 1'b1;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    gnt_q <= '0;
                    if (we_q) begin
                        mem[addr_q] <= wdata_q;
                        ptr_q       <= ptr_next;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        rdata_q  <= mem[addr_q];
                        rid_q    <= sel_q;
                        rvalid_q <= 1'b1;
                        state_q  <= StResp;
                    end
                end
                StResp: begin
                    rvalid_q <= 1'b0;
                    ptr_q    <= ptr_next;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.rid    = rid_q;
    assign bus.busy   = busy_q;
endmodule
